ex03_hex_conv: RTL and testbench
================================

Name: ex03_hex_conv

Overview:
- Registered hexadecimal-digit converter for the vending-machine display/datapath.
- Takes a 4-bit hex digit, either as a raw nibble or as an ASCII character.
- Outputs the binary nibble, a two-digit BCD decimal equivalent (0–15) and an active-low 7-segment hex glyph.
- Sits between the keypad/UART front end and the price/display logic.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low; 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hex_in  in  4  raw hex digit 0x0–0xF
- ascii_in  in  8  ASCII hex character
- ascii_valid  in  1  qualifies ascii_in for one cycle
- binary_out  out  4  binary value of the current digit
- dec_tens  out  4  BCD tens of the current digit (0 or 1)
- dec_ones  out  4  BCD ones of the current digit (0–9)
- seg  out  7  {g,f,e,d,c,b,a} hex glyph of the current digit
- ascii_err  out  1  last ascii_valid character was not a hex digit

Behaviour:
- All outputs are registered and cleared asynchronously when rst=1.
  - Reset values: binary_out=0, dec_tens=0, dec_ones=0, ascii_err=0.
  - seg shows the glyph "0": 7'b1000000 when SEG_ACTIVE_LOW=1, otherwise 7'b0111111.
- Digit source selection at each rising edge (rst=0):
  - ascii_valid=1 with '0'–'9' (0x30–0x39): digit = char−0x30; ascii_err<=0.
  - ascii_valid=1 with 'A'–'F' (0x41–0x46) or 'a'–'f' (0x61–0x66): digit = 10+(char−base); ascii_err<=0.
  - ascii_valid=1 with any other byte: ascii_err<=1. binary_out, dec_*, seg hold their previous values.
  - ascii_valid=0: digit = hex_in; ascii_err holds.
- Output updates: binary_out<=digit (identity mapping, e.g. 0xA→4'b1010).
  - dec_tens<=(digit>=10); dec_ones<=digit mod 10.
  - seg<=glyph(digit).
- Latency: exactly one clock edge from input to all outputs. No handshake, no backpressure. hex_in is sampled every cycle.
- Simultaneous ascii_valid and hex_in change: the ASCII path wins.
- Glyphs (active-high a–g): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. The active-low form is the bitwise inverse.
- Reset asserted mid-stream clears outputs immediately, without waiting for a clock. The first edge after deassertion loads the current input.
- No X propagation: all 16 nibble values are legal, and all 256 ASCII values have a defined outcome.

Decomposition:
- Shared package ex03_pkg:
  - ASCII range constants: ASCII_0, ASCII_9, ASCII_UA, ASCII_UF, ASCII_LA, ASCII_LF.
  - Function seg_glyph(nibble) returning the active-high 7-bit pattern.
  - Function to_bcd(nibble) returning {tens, ones}.
- One natural sub-module, ex03_ascii_decode: combinational, ascii_in[7:0] → {is_hex, nibble[3:0]}.
- Top level holds the source mux and the output registers.

Test Plan:
- Reset: assert rst with no clock. Outputs go to 0/0/0 immediately, seg=7'b1000000, ascii_err=0.
- Raw nibbles, ascii_valid=0, one edge each:
  - hex_in=0xA → binary 1010, tens 1, ones 0, seg ~77.
  - hex_in=0xF → 1111, 1/5, seg ~71.
  - hex_in=0x5 → 0101, 0/5, seg ~6D.
- Sweep hex_in 0x0–0xF, one per cycle. binary_out equals the previous cycle's hex_in. Decimal = hex_in in every case (0x9→0/9, 0xC→1/2, 0x0→0/0, 0x1→0/1).
- ASCII path:
  - 'c' (0x63) → binary 1100, ascii_err=0.
  - '7' → 0111.
  - 'G' (0x47) → ascii_err=1, binary_out holds 0111.
  - Next valid 'F' → 1111, ascii_err=0.
- Priority: ascii_valid=1 with '3' while hex_in=0xE → binary_out=0011.
- Reset mid-operation: binary_out=1111, assert rst between edges → immediate 0. Release rst with hex_in=0x9 → one edge later binary 1001, 0/9.

Source files
------------

// File: rtl/ex03_hex_conv_pkg.sv
// ex03_pkg: shared constants and helper functions for the hex-digit converter.
//   ASCII_*    : bounds of the three ASCII hex-digit ranges ('0'-'9', 'A'-'F', 'a'-'f')
//   seg_glyph  : 4-bit digit -> active-high {g,f,e,d,c,b,a} glyph
//   to_bcd     : 4-bit digit -> {tens, ones} BCD pair (tens is 0 or 1)
package ex03_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // A nibble never exceeds 15, so a single compare-and-subtract gives BCD.
  function automatic logic [7:0] to_bcd(input logic [3:0] nibble);
    logic [7:0] r;
    if (nibble >= 4'd10) r = {4'd1, nibble - 4'd10};
    else                 r = {4'd0, nibble};
    return r;
  endfunction

endpackage

// File: rtl/ex03_ascii_decode.sv
// ex03_ascii_decode: combinational ASCII hex-character decoder.
//   ascii_in : 8-bit character
//   is_hex   : 1 when ascii_in is '0'-'9', 'A'-'F' or 'a'-'f'
//   nibble   : digit value when is_hex, otherwise 0
module ex03_ascii_decode
  import ex03_pkg::*;
(
  input  logic [7:0] ascii_in,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // The low nibble of '0'-'9' is the digit itself; for 'A'-'F' and 'a'-'f'
  // the low nibble runs 1..6, so adding 9 yields 10..15.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (ascii_in >= ASCII_0 && ascii_in <= ASCII_9) begin
      is_hex = 1'b1;
      nibble = ascii_in[3:0];
    end else if ((ascii_in >= ASCII_UA && ascii_in <= ASCII_UF) ||
                 (ascii_in >= ASCII_LA && ascii_in <= ASCII_LF)) begin
      is_hex = 1'b1;
      nibble = ascii_in[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/ex03_hex_conv.sv
// ex03_hex_conv: registered hex-digit converter (raw nibble or ASCII character
// in; binary, two-digit BCD and 7-segment glyph out, one clock of latency).
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   hex_in      : raw digit, used whenever ascii_valid is low
//   ascii_in    : ASCII character, used when ascii_valid is high (takes priority)
//   binary_out  : digit value
//   dec_tens    : BCD tens (0 or 1); dec_ones: BCD ones (0-9)
//   seg         : {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   ascii_err   : last qualified character was not a hex digit
module ex03_hex_conv
  import ex03_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex_in,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic [3:0] binary_out,
  output logic [3:0] dec_tens,
  output logic [3:0] dec_ones,
  output logic [6:0] seg,
  output logic       ascii_err
);

  localparam logic [6:0] SEG_RESET = SEG_ACTIVE_LOW ? ~seg_glyph(4'h0) : seg_glyph(4'h0);

  logic       is_hex;
  logic [3:0] ascii_nibble;
  logic       load;
  logic [3:0] digit;
  logic [3:0] tens_next;
  logic [3:0] ones_next;
  logic [6:0] seg_next;

  ex03_ascii_decode u_ascii_decode (
    .ascii_in (ascii_in),
    .is_hex   (is_hex),
    .nibble   (ascii_nibble)
  );

  // Source mux: a qualified ASCII character wins over hex_in; a bad character
  // suppresses the load so the display keeps its previous digit.
  always_comb begin
    load  = 1'b1;
    digit = hex_in;
    if (ascii_valid) begin
      digit = ascii_nibble;
      load  = is_hex;
    end
    {tens_next, ones_next} = to_bcd(digit);
    seg_next = SEG_ACTIVE_LOW ? ~seg_glyph(digit) : seg_glyph(digit);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_out <= 4'd0;
      dec_tens   <= 4'd0;
      dec_ones   <= 4'd0;
      seg        <= SEG_RESET;
      ascii_err  <= 1'b0;
    end else begin
      if (load) begin
        binary_out <= digit;
        dec_tens   <= tens_next;
        dec_ones   <= ones_next;
        seg        <= seg_next;
      end
      if (ascii_valid) ascii_err <= ~is_hex;
    end
  end

endmodule

// File: tb/tb_ex03_hex_conv.sv
module tb_ex03_hex_conv;

  localparam bit SEG_ACTIVE_LOW = 1'b1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hex_in = 4'd0;
  logic [7:0] ascii_in = 8'd0;
  logic       ascii_valid = 1'b0;
  logic [3:0] binary_out;
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;
  logic [6:0] seg;
  logic       ascii_err;

  int n_checks = 0;
  int n_pass   = 0;

  ex03_hex_conv #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hex_in      (hex_in),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .binary_out  (binary_out),
    .dec_tens    (dec_tens),
    .dec_ones    (dec_ones),
    .seg         (seg),
    .ascii_err   (ascii_err)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference glyph table (active-high a-g), indexed by digit.
  logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] polar(input logic [6:0] ah);
    return SEG_ACTIVE_LOW ? ~ah : ah;
  endfunction

  // Behavioural model state: the digit on display and the error flag.
  int m_digit = 0;
  bit m_err   = 1'b0;

  task automatic model_step(input bit v, input logic [7:0] ch, input logic [3:0] h);
    int c;
    c = int'(ch);
    if (!v) begin
      m_digit = int'(h);
    end else if (c >= 48 && c <= 57) begin
      m_digit = c - 48; m_err = 1'b0;
    end else if (c >= 65 && c <= 70) begin
      m_digit = 10 + c - 65; m_err = 1'b0;
    end else if (c >= 97 && c <= 102) begin
      m_digit = 10 + c - 97; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".bin"},  32'(binary_out), 32'(m_digit));
    check({tag, ".tens"}, 32'(dec_tens),   32'(m_digit / 10));
    check({tag, ".ones"}, 32'(dec_ones),   32'(m_digit % 10));
    check({tag, ".seg"},  32'(seg),        32'(polar(glyph_tbl[m_digit])));
    check({tag, ".err"},  32'(ascii_err),  32'(m_err));
  endtask

  // Drive inputs just after an edge, advance one edge, update the model.
  task automatic drive(input bit v, input logic [7:0] ch, input logic [3:0] h);
    ascii_valid = v;
    ascii_in    = ch;
    hex_in      = h;
    @(posedge clk);
    model_step(v, ch, h);
    #1;
  endtask

  typedef struct {
    bit         valid;
    logic [7:0] ch;
    logic [3:0] hex;
    logic [3:0] e_bin;
    logic [3:0] e_tens;
    logic [3:0] e_ones;
    logic [6:0] e_glyph;
    bit         e_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    // Hand-derived vectors, applied in order (ascii_err and held digits carry over).
    vecs[0]  = '{1'b0, 8'h00, 4'hA, 4'hA, 4'd1, 4'd0, 7'h77, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 4'hF, 4'hF, 4'd1, 4'd5, 7'h71, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 4'h5, 4'h5, 4'd0, 4'd5, 7'h6D, 1'b0};
    vecs[3]  = '{1'b1, 8'h63, 4'h0, 4'hC, 4'd1, 4'd2, 7'h39, 1'b0}; // 'c'
    vecs[4]  = '{1'b1, 8'h37, 4'h0, 4'h7, 4'd0, 4'd7, 7'h07, 1'b0}; // '7'
    vecs[5]  = '{1'b1, 8'h47, 4'h0, 4'h7, 4'd0, 4'd7, 7'h07, 1'b1}; // 'G' rejected
    vecs[6]  = '{1'b0, 8'h00, 4'h2, 4'h2, 4'd0, 4'd2, 7'h5B, 1'b1}; // err holds
    vecs[7]  = '{1'b1, 8'h46, 4'h0, 4'hF, 4'd1, 4'd5, 7'h71, 1'b0}; // 'F'
    vecs[8]  = '{1'b1, 8'h33, 4'hE, 4'h3, 4'd0, 4'd3, 7'h4F, 1'b0}; // '3' beats hex_in
    vecs[9]  = '{1'b1, 8'h61, 4'h0, 4'hA, 4'd1, 4'd0, 7'h77, 1'b0}; // 'a'
    vecs[10] = '{1'b1, 8'h40, 4'h0, 4'hA, 4'd1, 4'd0, 7'h77, 1'b1}; // '@' just below 'A'
    vecs[11] = '{1'b1, 8'h39, 4'h0, 4'h9, 4'd0, 4'd9, 7'h6F, 1'b0}; // '9'

    // Asynchronous reset with the clock stopped.
    #1 rst = 1'b1;
    #1;
    check("rst.bin",  32'(binary_out), 32'd0);
    check("rst.tens", 32'(dec_tens),   32'd0);
    check("rst.ones", 32'(dec_ones),   32'd0);
    check("rst.seg",  32'(seg),        32'(polar(7'h3F)));
    check("rst.err",  32'(ascii_err),  32'd0);
    #2 rst = 1'b0;
    clk_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].ch, vecs[i].hex);
      check($sformatf("vec%0d.bin", i),  32'(binary_out), 32'(vecs[i].e_bin));
      check($sformatf("vec%0d.tens", i), 32'(dec_tens),   32'(vecs[i].e_tens));
      check($sformatf("vec%0d.ones", i), 32'(dec_ones),   32'(vecs[i].e_ones));
      check($sformatf("vec%0d.seg", i),  32'(seg),        32'(polar(vecs[i].e_glyph)));
      check($sformatf("vec%0d.err", i),  32'(ascii_err),  32'(vecs[i].e_err));
    end

    // Sweep every raw nibble.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 4'(i));
      check_model($sformatf("sweep%0d", i));
    end

    // Reset between edges: outputs clear before any clock edge.
    drive(1'b0, 8'h00, 4'hF);
    check("pre_rst.bin", 32'(binary_out), 32'hF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.bin", 32'(binary_out), 32'd0);
    check("mid_rst.seg", 32'(seg),        32'(polar(7'h3F)));
    m_digit = 0; m_err = 1'b0;
    hex_in = 4'h9;
    #1 rst = 1'b0;
    @(posedge clk);
    model_step(1'b0, 8'h00, 4'h9);
    #1;
    check("post_rst.bin",  32'(binary_out), 32'h9);
    check("post_rst.tens", 32'(dec_tens),   32'd0);
    check("post_rst.ones", 32'(dec_ones),   32'd9);

    // Randomised traffic against the model; half the characters are hex digits.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ch;
      string hexchars;
      hexchars = "0123456789ABCDEFabcdef";
      if ($urandom_range(0, 1) == 0) ch = hexchars[$urandom_range(0, 21)];
      else                           ch = 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), ch, 4'($urandom_range(0, 15)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
